// File: rtl/demux8_pkg.sv
// demux8_pkg: shared constants and types for the 8-way stream demultiplexer.
// Optional feature macro: DEMUX8_PERF_EN (per-channel load counters).
package demux8_pkg;

    localparam int CHANNELS = 8;
    localparam int PERF_W   = 16;

    typedef logic [2:0] chan_sel_t;

    // Occupancy of a one-entry channel register
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : demux8_pkg

// File: rtl/demux8_slot.sv
// demux8_slot: one-entry output register for a single channel.
// Load and drain may coincide; the new payload then replaces the old one
// and the slot stays FULL, giving one transfer per cycle per channel.
module demux8_slot
    import demux8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_t      r_state;
    slot_state_t      w_state_next;
    logic [WIDTH-1:0] r_data;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: fill on load, empty only on a drain without a refill
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_load) begin
                    w_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (i_drain && !i_load) begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            default: w_state_next = SLOT_EMPTY;
        endcase
    end

    // Payload changes only on load; it is kept even after the slot drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule : demux8_slot

// File: rtl/demux8_stream.sv
// demux8_stream: steers one valid/ready stream to one of eight channels,
// each backed by a one-entry register that drains independently.
// Optional feature macro: DEMUX8_PERF_EN adds per-channel saturating load
// counters readable through perf_sel/perf_count.
module demux8_stream
    import demux8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef DEMUX8_PERF_EN
    input  chan_sel_t                 perf_sel,
    input  logic                      perf_clr,
    output logic [PERF_W-1:0]         perf_count,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  chan_sel_t                 in_select,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data
);

    logic                w_in_ready;
    logic                w_accept;
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_drain;

    // Ready depends only on the addressed slot, never on in_valid, so a
    // stalled channel blocks only traffic aimed at it.
    assign w_in_ready = ~out_valid[in_select] | out_ready[in_select];
    assign w_accept   = in_valid & w_in_ready;
    assign in_ready   = w_in_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
            assign w_load[gi]  = w_accept & (in_select == chan_sel_t'(gi));
            assign w_drain[gi] = out_valid[gi] & out_ready[gi];

            demux8_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[gi]),
                .i_drain (w_drain[gi]),
                .i_data  (in_data),
                .o_valid (out_valid[gi]),
                .o_data  (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

`ifdef DEMUX8_PERF_EN
    logic [PERF_W-1:0] r_count [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_perf
            // Saturating load counter; clear wins over a coincident load
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count[gi] <= '0;
                end else if (perf_clr) begin
                    r_count[gi] <= '0;
                end else if (w_load[gi] && (r_count[gi] != {PERF_W{1'b1}})) begin
                    r_count[gi] <= r_count[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign perf_count = r_count[perf_sel];
`endif

endmodule : demux8_stream

// File: tb/tb_demux8_stream.sv
// tb_demux8_stream: directed and randomized checks of demux8_stream against
// a per-channel queue model. Define DEMUX8_PERF_EN to also exercise counters.
module tb_demux8_stream;

    localparam int WIDTH = 32;
    localparam int NCH   = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_select;
    logic [WIDTH-1:0]       in_data;
    logic [NCH-1:0]         out_valid;
    logic [NCH-1:0]         out_ready;
    logic [NCH*WIDTH-1:0]   out_data;
`ifdef DEMUX8_PERF_EN
    logic [2:0]             perf_sel;
    logic                   perf_clr;
    logic [15:0]            perf_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    demux8_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX8_PERF_EN
        .perf_sel  (perf_sel),
        .perf_clr  (perf_clr),
        .perf_count(perf_count),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_select (in_select),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // Advance to 1 time unit after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] d,
                         input logic [NCH-1:0] ordy);
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Reference model: each channel is a FIFO of capacity one
    logic [WIDTH-1:0] q [NCH][$];

    initial begin
        logic [NCH-1:0]   exp_v;
        logic             exp_rdy;
        logic [WIDTH-1:0] exp_d;
        int               accepted;
        int               cycles;

        rst_n = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
`ifdef DEMUX8_PERF_EN
        perf_sel = 3'd0;
        perf_clr = 1'b0;
`endif
        #12;
        check("reset_valid", 64'(out_valid), 64'h00);
        check("reset_data", 64'(out_data[63:0]), 64'h0);
        tick;
        rst_n = 1'b1;
        tick;

        // Test 1: async reset while slots 2 and 5 hold data
        drive(1'b1, 3'd2, 32'h22, '0); tick;
        drive(1'b1, 3'd5, 32'h55, '0); tick;
        drive(1'b0, 3'd2, '0, '0);
        check("t1_full_2_5", 64'(out_valid), 64'h24);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 64'(out_valid), 64'h00);
        check("t1_async_data5", 64'(ch(5)), 64'h0);
        tick;
        rst_n = 1'b1;
        #1;
        check("t1_ready_after", 64'(in_ready), 64'h1);
        tick;

        // Test 2: blocking on a full slot, other channel unaffected
        drive(1'b1, 3'd3, 32'hCAFE0003, '0);
        #1 check("t2_ready_first", 64'(in_ready), 64'h1);
        tick;
        check("t2_valid_08", 64'(out_valid), 64'h08);
        check("t2_data3", 64'(ch(3)), 64'hCAFE0003);
        drive(1'b1, 3'd3, 32'hDEAD0003, '0);
        #1 check("t2_ready_blocked", 64'(in_ready), 64'h0);
        tick;
        check("t2_data3_held", 64'(ch(3)), 64'hCAFE0003);
        drive(1'b1, 3'd4, 32'hCAFE0004, '0);
        #1 check("t2_ready_sel4", 64'(in_ready), 64'h1);
        tick;
        check("t2_valid_18", 64'(out_valid), 64'h18);
        check("t2_data4", 64'(ch(4)), 64'hCAFE0004);

        // Test 3: drain and refill slot 6 in one cycle
        drive(1'b1, 3'd6, 32'h60, '0); tick;
        drive(1'b1, 3'd6, 32'h66, 8'h40);
        #1 check("t3_ready", 64'(in_ready), 64'h1);
        tick;
        drive(1'b0, 3'd0, '0, '0);
        check("t3_valid6", 64'(out_valid[6]), 64'h1);
        check("t3_data6", 64'(ch(6)), 64'h66);

        // Test 6: drain all, data held while empty; then fill all and drain all at once
        drive(1'b0, 3'd3, '0, 8'hFF); tick;
        check("t6_pre_drain", 64'(out_valid), 64'h00);
        check("t6_hold_empty3", 64'(ch(3)), 64'hCAFE0003);
        for (int k = 0; k < NCH; k++) begin
            drive(1'b1, 3'(k), 32'hA0 + 32'(k), '0);
            tick;
        end
        drive(1'b0, 3'd0, '0, '0);
        check("t6_all_full", 64'(out_valid), 64'hFF);
        drive(1'b0, 3'd0, '0, 8'hFF); tick;
        check("t6_all_drained", 64'(out_valid), 64'h00);
        check("t6_hold_data7", 64'(ch(7)), 64'hA7);

        // Test 4: random stream with random backpressure against queue model
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), WIDTH'($urandom),
                  NCH'($urandom));
            #1;
            for (int k = 0; k < NCH; k++) exp_v[k] = (q[k].size() != 0);
            check("t4_valid", 64'(out_valid), 64'(exp_v));
            exp_rdy = (q[in_select].size() == 0) || out_ready[in_select];
            check("t4_ready", 64'(in_ready), 64'(exp_rdy));
            for (int k = 0; k < NCH; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    exp_d = q[k].pop_front();
                    check("t4_data", 64'(ch(k)), 64'(exp_d));
                end
            end
            if (in_valid && in_ready) begin
                q[in_select].push_back(in_data);
                accepted++;
            end
            tick;
            cycles++;
        end
        check("t4_accepted", 64'(accepted), 64'd1000);
        drive(1'b0, 3'd0, '0, 8'hFF);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (q[k].size() != 0) begin
                exp_d = q[k].pop_front();
                check("t4_final_data", 64'(ch(k)), 64'(exp_d));
            end
        end
        tick;
        check("t4_final_empty", 64'(out_valid), 64'h00);

`ifdef DEMUX8_PERF_EN
        // Test 5: counter increment, saturation and clear priority
        perf_clr = 1'b1; tick; perf_clr = 1'b0;
        perf_sel = 3'd0;
        check("t5_cleared", 64'(perf_count), 64'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd0, 32'(i), 8'h01); tick;
        end
        drive(1'b0, 3'd0, '0, 8'hFF); tick;
        check("t5_count3", 64'(perf_count), 64'd3);
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 3'd0, 32'(i), 8'h01); tick;
        end
        drive(1'b0, 3'd0, '0, 8'hFF); tick;
        check("t5_saturated", 64'(perf_count), 64'hFFFF);
        perf_sel = 3'd1;
        #1 check("t5_other_ch", 64'(perf_count), 64'h0);
        perf_sel = 3'd0;
        drive(1'b1, 3'd0, 32'h1, 8'h01);
        perf_clr = 1'b1;
        tick;
        perf_clr = 1'b0;
        drive(1'b0, 3'd0, '0, 8'hFF);
        check("t5_clr_priority", 64'(perf_count), 64'h0);
        tick;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux8_stream
